inst_imm_encoder: RTL

//  Inverse of the immediate generator: packs a 32-bit immediate, register specifiers and an
//  imm_type into a TinyRV1 instruction word (ADDI/SW/JAL/BNE).

---
 rtl/inst_imm_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/inst_imm_encoder.sv
// rtl/inst_imm_encoder.sv - packs imm/regs/type into a TinyRV1 ADDI/SW/JAL/BNE word behind an in-order output FIFO
// Optional immediate range flagging on out_err: INST_IMM_ENCODER_RANGE_CHECK_EN
module inst_imm_encoder #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [1:0]         in_type,
    input  logic [31:0]        in_imm,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [31:0]        out_inst,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]        w_enc_inst;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [COUNT_W-1:0] r_enc_count;
    logic [31:0]        r_mem_inst [DEPTH];

    always_comb begin
        w_enc_inst = 32'd0;
        case (in_type)
            2'd0: w_enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            2'd1: w_enc_inst = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            2'd2: w_enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default: w_enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                                   in_imm[4:1], in_imm[11], 7'b1100011};
        endcase
    end

    // Full/empty come from registered pointers only, so in_rdy never sees out_rdy
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign in_rdy  = !w_full;
    assign out_val = !w_empty;
    assign w_push  = in_val && !w_full;
    assign w_pop   = !w_empty && out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_enc_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_enc_count <= r_enc_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_inst[r_wr_ptr[AW-1:0]] <= w_enc_inst;
    end

    assign out_inst  = w_empty ? 32'd0 : r_mem_inst[r_rd_ptr[AW-1:0]];
    assign enc_count = r_enc_count;

`ifdef INST_IMM_ENCODER_RANGE_CHECK_EN
    logic w_enc_err;
    logic r_mem_err [DEPTH];

    // In range means every bit above the field's sign bit equals that sign bit
    always_comb begin
        w_enc_err = 1'b0;
        case (in_type)
            2'd0, 2'd1: w_enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            2'd2:       w_enc_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            default:    w_enc_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_err[r_wr_ptr[AW-1:0]] <= w_enc_err;
    end

    assign out_err = w_empty ? 1'b0 : r_mem_err[r_rd_ptr[AW-1:0]];
`else
    logic w_unused_imm;
    assign w_unused_imm = ^in_imm[31:21];
    assign out_err      = 1'b0;
`endif
endmodule
